// File: rtl/regfile_dump_reader.sv
// Debug readout engine: sweeps a register range through the bank's rs read port
// and streams each value with its address on a valid/ready interface.
module regfile_dump_reader #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] first_addr,
  input  logic [AWIDTH-1:0] last_addr,
  output logic [AWIDTH-1:0] rf_addr_rs,
  output logic              rf_req_rs,
  input  logic [15:0]       rf_rs,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [15:0]       dout_data,
  output logic [AWIDTH-1:0] dout_addr,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] cur, last_q;
  logic              issue_done;
  logic              rd_vld;
  logic [AWIDTH-1:0] rd_addr;

  logic [15:0]       fifo_data [2];
  logic [AWIDTH-1:0] fifo_addr [2];
  logic              fifo_last [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic [1:0]        inflight;
  logic [2:0]        occupancy;
  logic              issue, push, pop, drained;
  logic [AWIDTH-1:0] issue_addr, issue_end;

  // Outstanding reads: one in the request register, one on the bank output.
  assign inflight  = 2'(rf_req_rs) + 2'(rd_vld);
  assign occupancy = 3'(count) + 3'(inflight);
  assign drained   = (count == 2'd0) && (inflight == 2'd0);
  assign push      = rd_vld;
  assign pop       = dout_valid && dout_ready;

  // The start cycle itself issues first_addr so the first beat appears three cycles later.
  assign issue_addr = (state == IDLE) ? first_addr : cur;
  assign issue_end  = (state == IDLE) ? last_addr  : last_q;
  assign issue = !abort &&
                 (((state == IDLE) && start) ||
                  ((state == RUN) && !issue_done && (occupancy < 3'd2)));

  assign dout_valid = (count != 2'd0);
  assign dout_data  = fifo_data[rd_ptr];
  assign dout_addr  = fifo_addr[rd_ptr];
  assign dout_last  = fifo_last[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = RUN;
      RUN:     if (issue_done) state_nxt = DRAIN;
      DRAIN:   if (drained)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DRAIN) && drained && !abort;
  end

  // NOTE: the two-entry buffer is reset too, because its head drives dout_* and those must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      rf_req_rs  <= 1'b0;
      rf_addr_rs <= '0;
      cur        <= '0;
      last_q     <= '0;
      issue_done <= 1'b0;
      rd_vld     <= 1'b0;
      rd_addr    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else if (abort) begin
      // A read still in the bank pipeline is dropped by clearing rd_vld.
      rf_req_rs  <= 1'b0;
      issue_done <= 1'b0;
      rd_vld     <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      rf_req_rs <= issue;
      if ((state == IDLE) && start) last_q <= last_addr;
      if (issue) begin
        rf_addr_rs <= issue_addr;
        cur        <= issue_addr + AWIDTH'(1);
        issue_done <= (issue_addr == issue_end);
      end
      rd_vld  <= rf_req_rs;
      rd_addr <= rf_addr_rs;
      if (push) begin
        fifo_data[wr_ptr] <= rf_rs;
        fifo_addr[wr_ptr] <= rd_addr;
        fifo_last[wr_ptr] <= (rd_addr == last_q);
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader with a behavioural register bank.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [7:0]  first_addr, last_addr;
  logic [7:0]  rf_addr_rs;
  logic        rf_req_rs;
  logic [15:0] rf_rs;
  logic        dout_valid, dout_ready;
  logic [15:0] dout_data;
  logic [7:0]  dout_addr;
  logic        dout_last, busy, done;

  regfile_dump_reader #(.AWIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_addr_rs(rf_addr_rs), .rf_req_rs(rf_req_rs), .rf_rs(rf_rs),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_addr(dout_addr), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] bank [256];
  always @(posedge clk) if (rf_req_rs) rf_rs <= bank[rf_addr_rs];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  int          epoch = 0, seen_epoch = 0;
  int          reqs = 0, accs = 0, done_cnt = 0, done_cyc = 0;
  int          first_valid_cyc = -1;
  int          start_cyc = 0;
  bit          prev_stall = 0;
  logic [7:0]  hold_addr;
  logic [15:0] hold_data;
  logic        hold_last;

  // Monitor: collects accepted beats, checks stall stability and outstanding reads.
  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      beats.delete();
      reqs = 0; accs = 0; done_cnt = 0; first_valid_cyc = -1; prev_stall = 0;
    end
    if (prev_stall)
      check("stall_hold", {dout_valid, dout_last, dout_addr, dout_data},
            {1'b1, hold_last, hold_addr, hold_data});
    if (rf_req_rs) begin
      reqs++;
      check("outstanding_le_2", 32'(reqs - accs <= 2), 32'd1);
    end
    if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (dout_valid && dout_ready) begin
      accs++;
      beats.push_back('{dout_addr, dout_data, dout_last, cyc});
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = dout_valid && !dout_ready && !abort && !rst;
    hold_addr = dout_addr; hold_data = dout_data; hold_last = dout_last;
  end

  logic [15:0] pat = 16'b1011_0010_1101_0110;

  task automatic do_start(input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    epoch++;
    first_addr = f; last_addr = l; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    bit timed_out = 1'b1;
    int k = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (rand_ready) dout_ready = (k >= 6 && k < 16) ? 1'b0 : pat[k % 16];
      k++;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("sweep_completes", 32'(!timed_out), 32'd1);
    dout_ready = 1'b1;
  endtask

  task automatic check_sweep(input logic [7:0] f, input int n);
    logic [7:0] a;
    check("beat_count", beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      a = f + 8'(i);
      check("beat_addr", beats[i].addr, a);
      check("beat_data", beats[i].data, 16'hA000 + 16'(a));
      check("beat_last", beats[i].last, 32'(i == n - 1));
    end
    check("first_valid_latency", first_valid_cyc - start_cyc, 3);
    check("done_pulses", done_cnt, 1);
    if (beats.size() > 0)
      check("done_timing", done_cyc, beats[beats.size()-1].cyc + 1);
    check("busy_after", busy, 0);
  endtask

  task automatic check_reset_outputs;
    check("rst_req", rf_req_rs, 0);
    check("rst_addr_rs", rf_addr_rs, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_data", dout_data, 0);
    check("rst_addr", dout_addr, 0);
    check("rst_last", dout_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0; dout_ready = 1'b1;
    for (int i = 0; i < 256; i++) bank[i] = 16'hA000 + 16'(i);
    #12;
    check_reset_outputs();
    @(negedge clk) rst = 1'b0;

    // Plain range, consumer always ready
    do_start(8'h10, 8'h13);
    wait_idle(100, 1'b0);
    check_sweep(8'h10, 4);

    // Wrap-around through 0xFF
    do_start(8'hFE, 8'h01);
    wait_idle(100, 1'b0);
    check_sweep(8'hFE, 4);

    // Single-register sweep
    do_start(8'h05, 8'h05);
    wait_idle(100, 1'b0);
    check_sweep(8'h05, 1);

    // Back-pressure with a 10-cycle stall
    do_start(8'h00, 8'h0F);
    wait_idle(400, 1'b1);
    check_sweep(8'h00, 16);

    // Abort during a stalled full sweep
    dout_ready = 1'b0;
    do_start(8'h00, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    check("pre_abort_valid", dout_valid, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", dout_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_req", rf_req_rs, 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    dout_ready = 1'b1;
    do_start(8'h20, 8'h21);
    wait_idle(100, 1'b0);
    check_sweep(8'h20, 2);

    // Asynchronous reset between clock edges
    do_start(8'h00, 8'hFF);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_no_done", done_cnt, 0);
    check("reset_idle", busy, 0);

    // start while busy is ignored
    do_start(8'h30, 8'h33);
    first_addr = 8'h50; last_addr = 8'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100, 1'b0);
    check_sweep(8'h30, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
